mesh_mvm_top: RTL and testbench

Weight-stationary signed matrix-vector multiply engine: y = W·x. It holds a ROWS×COLS signed weight matrix, loaded one element per cycle through a preload port. On a start pulse it computes ROWS signed dot products against a COLS-element input vector and presents them on a flat result bus. It is the compute top level of the mesh datapath; a host loads the weights, then pulses start.

---
 rtl/mesh_mvm_top.sv | 139 +++++++++++++
 tb/tb_mesh_mvm_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_mvm_top.sv
// Weight-stationary signed matrix-vector engine: y = W*x over a preloaded ROWSxCOLS weight array.
// One column of the product is accumulated into every row per cycle while in COMPUTE.
module mesh_mvm_top #(
  parameter int DW      = 8,
  parameter int ROWS    = 40,
  parameter int COLS    = 40,
  parameter int ROW_W   = 7,
  parameter int COL_W   = 7,
  parameter int CYCLE_W = 9,
  parameter int ACC_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     preload_valid,
  input  logic [ROW_W+COL_W-1:0]   preload_addr,
  input  logic [DW-1:0]            preload_data,
  input  logic [COLS*DW-1:0]       x_vector_flat,
  output logic [ROWS*ACC_W-1:0]    result_flat
);

  localparam int CI_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CYCLE_W-1:0]        cycle_q, cycle_d;
  logic signed [DW-1:0]      w_q      [ROWS][COLS];
  logic signed [DW-1:0]      w_d      [ROWS][COLS];
  logic signed [DW-1:0]      x_q      [COLS];
  logic signed [DW-1:0]      x_d      [COLS];
  logic signed [ACC_W-1:0]   acc_q    [ROWS];
  logic signed [ACC_W-1:0]   acc_d    [ROWS];
  logic signed [ACC_W-1:0]   result_q [ROWS];
  logic signed [ACC_W-1:0]   result_d [ROWS];

  logic [ROW_W-1:0]          pre_row_s;
  logic [COL_W-1:0]          pre_col_s;
  logic [CI_W-1:0]           col_idx_s;

  assign pre_row_s = preload_addr[ROW_W+COL_W-1:COL_W];
  assign pre_col_s = preload_addr[COL_W-1:0];
  assign col_idx_s = cycle_q[CI_W-1:0];

  // Full-precision signed product, then sign-extended or truncated to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [DW-1:0] a,
                                                       input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = a * b;
    return ACC_W'(p);
  endfunction

  // Next-state, weight write, vector latch and accumulation logic.
  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    w_d      = w_q;
    x_d      = x_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        // Address decode by match: out-of-range rows/cols never hit any cell.
        if (preload_valid) begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (pre_row_s == ROW_W'(r) && pre_col_s == COL_W'(c)) begin
                w_d[r][c] = preload_data;
              end else begin
                w_d[r][c] = w_q[r][c];
              end
            end
          end
        end else begin
          w_d = w_q;
        end
        if (start) begin
          for (int c = 0; c < COLS; c++) begin
            x_d[c] = x_vector_flat[c*DW +: DW];
          end
          for (int r = 0; r < ROWS; r++) begin
            acc_d[r] = '0;
          end
          cycle_d = '0;
          state_d = COMPUTE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        for (int r = 0; r < ROWS; r++) begin
          acc_d[r] = acc_q[r] + mac_term(w_q[r][col_idx_s], x_q[col_idx_s]);
        end
        cycle_d = cycle_q + CYCLE_W'(1);
        if (cycle_q == CYCLE_W'(COLS - 1)) begin
          state_d = DONE;
        end else begin
          state_d = COMPUTE;
        end
      end
      DONE: begin
        result_d = acc_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, storage and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cycle_q  <= '0;
      w_q      <= '{default: '0};
      x_q      <= '{default: '0};
      acc_q    <= '{default: '0};
      result_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      w_q      <= w_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_res
    assign result_flat[r*ACC_W +: ACC_W] = result_q[r];
  end

endmodule

// File: tb/tb_mesh_mvm_top.sv
// Scoreboard bench for mesh_mvm_top: stimulus queues expected result vectors with a due cycle,
// and a negedge monitor compares result_flat against each entry once it falls due.
module tb_mesh_mvm_top;

  localparam int DW      = 8;
  localparam int ROWS    = 40;
  localparam int COLS    = 40;
  localparam int ROW_W   = 7;
  localparam int COL_W   = 7;
  localparam int CYCLE_W = 9;
  localparam int ACC_W   = 16;
  localparam int LAT     = COLS + 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     preload_valid;
  logic [ROW_W+COL_W-1:0]   preload_addr;
  logic signed [DW-1:0]     preload_data;
  logic [COLS*DW-1:0]       x_vector_flat;
  logic [ROWS*ACC_W-1:0]    result_flat;

  logic signed [DW-1:0]     w_m [ROWS][COLS];
  logic signed [DW-1:0]     x_m [COLS];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0]             due;
    logic [7:0]              id;
    logic [ROWS*ACC_W-1:0]   exp;
  } sb_t;

  sb_t sb[$];

  mesh_mvm_top #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
    .CYCLE_W(CYCLE_W), .ACC_W(ACC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .preload_valid (preload_valid),
    .preload_addr  (preload_addr),
    .preload_data  (preload_data),
    .x_vector_flat (x_vector_flat),
    .result_flat   (result_flat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    x_vector_flat = '0;
    for (int c = 0; c < COLS; c++) x_vector_flat[c*DW +: DW] = x_m[c];
  end

  function automatic logic [ROWS*ACC_W-1:0] model_y();
    logic [ROWS*ACC_W-1:0] v;
    logic signed [ACC_W-1:0] acc;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      acc = '0;
      for (int c = 0; c < COLS; c++) acc = acc + w_m[r][c] * x_m[c];
      v[r*ACC_W +: ACC_W] = acc;
    end
    return v;
  endfunction

  // Hand-derived closed form for w[r][c]=r+c, x[c]=c+1.
  function automatic logic [ROWS*ACC_W-1:0] formula_full();
    logic [ROWS*ACC_W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[r*ACC_W +: ACC_W] = 16'(820 * r + 21320);
    return v;
  endfunction

  task automatic expect_at(input int due, input int id, input logic [ROWS*ACC_W-1:0] v);
    sb_t e;
    e.due = 32'(due);
    e.id  = 8'(id);
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preload(input int r, input int c, input logic signed [DW-1:0] d, input bit taken);
    preload_valid = 1'b1;
    preload_addr  = {7'(r), 7'(c)};
    preload_data  = d;
    if (taken && r < ROWS && c < COLS) w_m[r][c] = d;
    tick(1);
    preload_valid = 1'b0;
  endtask

  task automatic start_run(input int id, input bit push, input logic [ROWS*ACC_W-1:0] v);
    start = 1'b1;
    if (push) expect_at(cyc + LAT, id, v);
    tick(1);
    start         = 1'b0;
    preload_valid = 1'b0;
  endtask

  task automatic check_entry(input sb_t e);
    logic signed [ACC_W-1:0] got;
    logic signed [ACC_W-1:0] req;
    for (int r = 0; r < ROWS; r++) begin
      got = result_flat[r*ACC_W +: ACC_W];
      req = e.exp[r*ACC_W +: ACC_W];
      n_cmp++;
      if (got !== req) begin
        n_fail++;
        $display("FAIL sb_id=%0d row=%0d actual=%0d required=%0d at cyc=%0d",
                 e.id, r, got, req, cyc);
      end
    end
  endtask

  // Monitor: compare every queued expectation that has fallen due.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= 32'(cyc)) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    preload_valid = 1'b0;
    preload_addr  = '0;
    preload_data  = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_m[r][c] = '0;
    for (int c = 0; c < COLS; c++) x_m[c] = '0;

    // Reset for two cycles.
    expect_at(2, 1, '0);
    tick(2);
    rst = 1'b0;

    // Start with no weights loaded.
    for (int c = 0; c < COLS; c++) x_m[c] = 8'(c + 1);
    start_run(2, 1'b1, '0);
    tick(LAT + 3);

    // Full load w=r+c, x=c+1; mid-run stray start, busy preload and x change.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) preload(r, c, 8'(r + c), 1'b1);
    expect_at(cyc + LAT - 1, 4, '0);
    start_run(3, 1'b1, formula_full());
    tick(9);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    preload(0, 0, 8'sd100, 1'b0);
    for (int c = 0; c < COLS; c++) x_m[c] = 8'sd5;
    tick(35);

    // x all ones: result held until DONE, then 40r+780.
    for (int c = 0; c < COLS; c++) x_m[c] = 8'sd1;
    expect_at(cyc + LAT - 1, 5, formula_full());
    start_run(6, 1'b1, model_y());
    tick(LAT + 3);

    // Out-of-range writes, then row 0 all -128 with x all -128.
    preload(40, 0, 8'sd7, 1'b0);
    preload(0, 40, 8'sd7, 1'b0);
    preload(127, 127, 8'sd7, 1'b0);
    for (int c = 0; c < COLS; c++) preload(0, c, -8'sd128, 1'b1);
    for (int c = 0; c < COLS; c++) x_m[c] = -8'sd128;
    start_run(7, 1'b1, model_y());
    tick(LAT + 3);

    // Only x[0] nonzero: row0 = 16384.
    for (int c = 1; c < COLS; c++) x_m[c] = '0;
    start_run(8, 1'b1, model_y());
    tick(LAT + 3);

    // Preload and start in the same cycle.
    for (int c = 0; c < COLS; c++) x_m[c] = 8'sd1;
    preload_valid = 1'b1;
    preload_addr  = {7'd5, 7'd3};
    preload_data  = 8'sd50;
    w_m[5][3]     = 8'sd50;
    start_run(9, 1'b1, model_y());
    tick(LAT + 3);

    // Reset mid-compute, then a fresh load and run.
    start_run(10, 1'b0, '0);
    tick(15);
    rst = 1'b1;
    expect_at(cyc + 1, 11, '0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_m[r][c] = '0;
    tick(1);
    rst = 1'b0;
    for (int c = 0; c < COLS; c++) preload(2, c, 8'sd1, 1'b1);
    for (int c = 0; c < COLS; c++) x_m[c] = 8'(c);
    start_run(12, 1'b1, model_y());
    tick(LAT + 3);

    for (int k = 0; k < 100 && sb.size() > 0; k++) tick(1);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain pending_entries=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
